// File: rtl/fmult_arbiter_pkg.sv
// Shared types and IEEE-754 single-precision constants for the fmult arbiter.
package fmult_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          MAN_MSB  = 22;

  // Classification bits {nan, inf, zero} of a single-precision value.
  function automatic logic [2:0] fp_flags(input logic [31:0] v);
    logic exp_max_s;
    logic exp_zero_s;
    logic man_zero_s;
    exp_max_s  = (v[EXP_MSB:EXP_LSB] == EXP_MAX);
    exp_zero_s = (v[EXP_MSB:EXP_LSB] == 8'h00);
    man_zero_s = (v[MAN_MSB:0] == 23'd0);
    return {exp_max_s & ~man_zero_s, exp_max_s & man_zero_s, exp_zero_s & man_zero_s};
  endfunction

endpackage

// File: rtl/fmult.sv
// Combinational single-precision multiplier: truncating, denormals flushed to zero,
// every NaN result collapsed to the canonical quiet NaN.
module fmult
  import fmult_arbiter_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic [7:0]        a_exp_s, b_exp_s;
  logic [22:0]       a_man_s, b_man_s, man_s;
  logic              a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s, sign_s;
  logic [47:0]       prod_s;
  logic signed [9:0] exp_s;
  logic              unused_low_s;

  assign a_exp_s  = a_i[EXP_MSB:EXP_LSB];
  assign b_exp_s  = b_i[EXP_MSB:EXP_LSB];
  assign a_man_s  = a_i[MAN_MSB:0];
  assign b_man_s  = b_i[MAN_MSB:0];
  assign sign_s   = a_i[SIGN_BIT] ^ b_i[SIGN_BIT];
  assign a_nan_s  = (a_exp_s == EXP_MAX) && (a_man_s != 23'd0);
  assign b_nan_s  = (b_exp_s == EXP_MAX) && (b_man_s != 23'd0);
  assign a_inf_s  = (a_exp_s == EXP_MAX) && (a_man_s == 23'd0);
  assign b_inf_s  = (b_exp_s == EXP_MAX) && (b_man_s == 23'd0);
  assign a_zero_s = (a_exp_s == 8'h00);
  assign b_zero_s = (b_exp_s == 8'h00);

  assign prod_s = {24'd0, 1'b1, a_man_s} * {24'd0, 1'b1, b_man_s};
  assign exp_s  = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s})
                + $signed({9'd0, prod_s[47]}) - 10'sd127;
  assign man_s  = prod_s[47] ? prod_s[46:24] : prod_s[45:23];
  assign unused_low_s = ^prod_s[22:0];

  // Special operands first, then exponent overflow/underflow, then the normal product.
  always_comb begin
    p_o = 32'd0;
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      p_o = QNAN;
    end else if (a_inf_s || b_inf_s) begin
      p_o = {sign_s, EXP_MAX, 23'd0};
    end else if (a_zero_s || b_zero_s) begin
      p_o = {sign_s, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      p_o = {sign_s, EXP_MAX, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      p_o = {sign_s, 31'd0};
    end else begin
      p_o = {sign_s, exp_s[7:0], man_s};
    end
  end

endmodule

// File: rtl/fmult_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr_i, wrapping at N.
module fmult_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] cand_s;
  logic        hit_s;

  // Walk candidates ptr, ptr+1, ... (mod N); the first requesting one wins.
  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    grant_o = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(N)) begin
        cand_s = cand_s - (IW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      hit_s = 1'b0;
      for (int j = 0; j < N; j++) begin
        hit_s = (cand_s == (IW+1)'(j)) ? req_i[j] : hit_s;
      end
      if (hit_s && !any_o) begin
        idx_o = cand_s[IW-1:0];
        any_o = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
    for (int i = 0; i < N; i++) begin
      grant_o[i] = any_o && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/fmult_arbiter.sv
// Round-robin arbiter sharing one fmult among NUM_REQ requesters (IDLE -> CALC -> RESP).
// Define FMULT_ARB_FLAGS_EN to add resp_flags {nan, inf, zero} registered with resp_data.
module fmult_arbiter
  import fmult_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
`ifdef FMULT_ARB_FLAGS_EN
  output logic [2:0]             resp_flags,
  output logic [31:0]            resp_data
`else
  output logic [31:0]            resp_data
`endif
);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q, ptr_d, id_q, pick_idx_s;
  logic [NUM_REQ-1:0]  pick_grant_s;
  logic                pick_any_s;
  logic [31:0]         op_a_q, op_b_q, sel_a_d, sel_b_d, prod_s, resp_data_q;
  logic                resp_valid_q;

  fmult_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  fmult u_fmult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod_s)
  );

  // Operand mux for the current winner.
  always_comb begin
    sel_a_d = 32'd0;
    sel_b_d = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_d = (pick_idx_s == ID_W'(i)) ? req_a[32*i +: 32] : sel_a_d;
      sel_b_d = (pick_idx_s == ID_W'(i)) ? req_b[32*i +: 32] : sel_b_d;
    end
  end

  assign ptr_d     = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
  assign req_ready = ((state_q == IDLE) && !rst) ? pick_grant_s : '0;

  // Main FSM; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any_s) begin
            op_a_q  <= sel_a_d;
            op_b_q  <= sel_b_d;
            id_q    <= pick_idx_s;
            state_q <= CALC;
          end
        end
        CALC: begin
          resp_data_q  <= prod_s;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            ptr_q        <= ptr_d;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;

`ifdef FMULT_ARB_FLAGS_EN
  logic [2:0] flags_q;

  // Flags are captured on the same edge as the product they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (state_q == CALC) begin
      flags_q <= fp_flags(prod_s);
    end else begin
      flags_q <= flags_q;
    end
  end

  assign resp_flags = flags_q;
`endif

endmodule

// File: tb/tb_fmult_arbiter.sv
// Directed self-checking bench for fmult_arbiter (NUM_REQ=2, ID_W=1).
module tb_fmult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [0:0]  resp_id;
  logic [31:0] resp_data;
`ifdef FMULT_ARB_FLAGS_EN
  logic [2:0]  resp_flags;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fmult_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
`ifdef FMULT_ARB_FLAGS_EN
    .resp_flags (resp_flags),
`endif
    .resp_data  (resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
    req_a = {a1, a0};
    req_b = {b1, b0};
  endtask

  // One full operation from IDLE with resp_ready=1: grant, CALC, RESP, handshake.
  task automatic op(input string tag, input logic [1:0] exp_grant, input logic exp_id,
                    input logic [31:0] exp_data, input logic [2:0] exp_flags, input logic keep);
    resp_ready = 1'b1;
    #1;
    chk({tag, "_grant"}, {30'd0, req_ready}, {30'd0, exp_grant});
    tick;
    if (!keep) req_valid = req_valid & ~exp_grant;
    #1;
    chk({tag, "_calc_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, "_calc_valid"}, {31'd0, resp_valid}, 32'd0);
    tick;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, exp_id});
`ifdef FMULT_ARB_FLAGS_EN
    chk({tag, "_flags"}, {29'd0, resp_flags}, {29'd0, exp_flags});
`else
    if (exp_flags == 3'b111) $display("note: flags argument unused in this build");
`endif
    tick;
    chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    set_ops(32'h4234_851F, 32'h427C_851F, 32'h4049_999A, 32'hC166_3D71);
    tick;
    tick;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_id", {31'd0, resp_id}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
`ifdef FMULT_ARB_FLAGS_EN
    chk("rst_flags", {29'd0, resp_flags}, 32'd0);
`endif

    // Single request from requester 0.
    req_valid = 2'b01;
    rst = 1'b0;
    op("single", 2'b01, 1'b0, 32'h4532_10E9, 3'b000, 1'b0);

    // Contention from reset: 0 first, then 1 with no extra bubble.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_valid = 2'b11;
    op("cont0", 2'b01, 1'b0, 32'h4532_10E9, 3'b000, 1'b0);
    op("cont1", 2'b10, 1'b1, 32'hC235_5062, 3'b000, 1'b0);

    // Backpressure with requester 1 waiting behind.
    set_ops(32'hC152_6666, 32'hC240_A3D7, 32'h7F80_0000, 32'hFF80_0000);
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    #1;
    chk("bp_grant", {30'd0, req_ready}, 32'd1);
    tick;
    req_valid = 2'b10;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_hold_data", resp_data, 32'h441E_5374);
      chk("bp_hold_ready", {30'd0, req_ready}, 32'd0);
      tick;
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_last_data", resp_data, 32'h441E_5374);
    chk("bp_last_ready", {30'd0, req_ready}, 32'd0);
    tick;
    op("inf", 2'b10, 1'b1, 32'hFF80_0000, 3'b010, 1'b0);

    // Remaining special values; pointer alternates 0,1,0.
    set_ops(32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000);
    req_valid = 2'b01;
    op("zero", 2'b01, 1'b0, 32'h0000_0000, 3'b001, 1'b0);
    req_valid = 2'b10;
    op("inf_x_zero", 2'b10, 1'b1, 32'h7FC0_0000, 3'b100, 1'b0);
    set_ops(32'h7F80_0000, 32'h7F80_000D, 32'h4049_999A, 32'hC166_3D71);
    req_valid = 2'b01;
    op("nan", 2'b01, 1'b0, 32'h7FC0_0000, 3'b100, 1'b0);

    // Reset during CALC of a requester-1 operation (pointer is 1 here).
    req_valid = 2'b10;
    #1;
    chk("mid_grant", {30'd0, req_ready}, 32'd2);
    tick;
    req_valid = 2'b00;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_id", {31'd0, resp_id}, 32'd0);
    chk("mid_data", resp_data, 32'd0);
    tick;
    chk("mid_noresp1", {31'd0, resp_valid}, 32'd0);
    tick;
    chk("mid_noresp2", {31'd0, resp_valid}, 32'd0);
    set_ops(32'h4234_851F, 32'h427C_851F, 32'h4049_999A, 32'hC166_3D71);
    req_valid = 2'b11;
    op("post_rst", 2'b01, 1'b0, 32'h4532_10E9, 3'b000, 1'b0);

    // Fairness with both requesters continuously valid.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) op("fair0", 2'b01, 1'b0, 32'h4532_10E9, 3'b000, 1'b1);
      else            op("fair1", 2'b10, 1'b1, 32'hC235_5062, 3'b000, 1'b1);
    end
    req_valid = 2'b00;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
